// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index and MEM-stage access FSM states.
package lc3b_types;

    localparam int unsigned REG_IDX_W = 3;

    typedef logic [REG_IDX_W-1:0] lc3b_reg;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_IND2 = 1'b1
    } mem_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: ID reads a register that the load in EX has not yet produced.
module hazard_detect #(
    parameter int unsigned REG_IDX_WIDTH = 3
) (
    input  logic                     ex_valid_i,
    input  logic                     ex_is_load_i,
    input  logic [REG_IDX_WIDTH-1:0] ex_dest_i,
    input  logic                     id_valid_i,
    input  logic                     id_uses_sr1_i,
    input  logic                     id_uses_sr2_i,
    input  logic [REG_IDX_WIDTH-1:0] id_sr1_i,
    input  logic [REG_IDX_WIDTH-1:0] id_sr2_i,
    output logic                     hz_o
);

    logic sr1_match;
    logic sr2_match;

    assign sr1_match = id_uses_sr1_i && (id_sr1_i == ex_dest_i);
    assign sr2_match = id_uses_sr2_i && (id_sr2_i == ex_dest_i);
    assign hz_o      = ex_valid_i && ex_is_load_i && id_valid_i && (sr1_match || sr2_match);

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline: MEM access FSM (incl. LDI/STI),
// load-use bubble insertion, branch redirect and a saturating stall-cycle counter.
module pipeline_control
    import lc3b_types::*;
#(
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned REG_IDX_WIDTH = REG_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_req,
    input  logic                     icache_resp,
    input  logic                     id_valid,
    input  logic                     id_uses_sr1,
    input  logic                     id_uses_sr2,
    input  logic [REG_IDX_WIDTH-1:0] id_sr1,
    input  logic [REG_IDX_WIDTH-1:0] id_sr2,
    input  logic                     ex_valid,
    input  logic                     ex_is_load,
    input  logic [REG_IDX_WIDTH-1:0] ex_dest,
    input  logic                     mem_valid,
    input  logic                     mem_access,
    input  logic                     mem_indirect,
    input  logic                     mem_br_taken,
    input  logic                     dcache_resp,
    output logic                     load_pc,
    output logic                     pc_sel,
    output logic                     load_if_id,
    output logic                     load_id_ex,
    output logic                     load_ex_mem,
    output logic                     load_mem_wb,
    output logic                     flush_if_id,
    output logic                     flush_id_ex,
    output logic                     flush_ex_mem,
    output logic                     mem_ind_sel,
    output logic [CNT_WIDTH-1:0]     stall_cycles
);

    mem_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic                 mem_busy;
    logic                 mem_done;
    logic                 fetch_stall;
    logic                 gstall;
    logic                 br;
    logic                 hz;

    hazard_detect #(
        .REG_IDX_WIDTH(REG_IDX_WIDTH)
    ) u_hazard_detect (
        .ex_valid_i   (ex_valid),
        .ex_is_load_i (ex_is_load),
        .ex_dest_i    (ex_dest),
        .id_valid_i   (id_valid),
        .id_uses_sr1_i(id_uses_sr1),
        .id_uses_sr2_i(id_uses_sr2),
        .id_sr1_i     (id_sr1),
        .id_sr2_i     (id_sr2),
        .hz_o         (hz)
    );

    assign mem_busy    = mem_valid && mem_access;
    assign mem_done    = !mem_busy
                      || ((state_q == M_IDLE) && dcache_resp && !mem_indirect)
                      || ((state_q == M_IND2) && dcache_resp);
    assign fetch_stall = if_req && !icache_resp;
    assign gstall      = !mem_done || fetch_stall;
    assign br          = mem_valid && mem_br_taken && !gstall;

    // MEM access FSM: the first LDI/STI response moves on to the second access
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            M_IDLE: if (mem_busy && mem_indirect && dcache_resp) state_d = M_IND2;
            M_IND2: if (dcache_resp) state_d = M_IDLE;
            default: state_d = M_IDLE;
        endcase
    end

    // Priority: global stall freezes everything, then branch redirect, then load-use bubble
    always_comb begin
        load_pc      = 1'b0;
        pc_sel       = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        mem_ind_sel  = rst_n && (state_q == M_IND2);
        if (rst_n && !gstall) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (br) begin
                load_pc      = 1'b1;
                pc_sel       = 1'b1;
                load_if_id   = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (hz) begin
                flush_id_ex = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!load_pc && (stall_cycles_q != {CNT_WIDTH{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= M_IDLE;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: driver pushes model expectations, negedge monitor compares.
module tb_pipeline_control;

    localparam int unsigned CW     = 16;
    localparam int          CNTMAX = 65535;

    typedef struct packed {
        logic       if_req;
        logic       icache_resp;
        logic       id_valid;
        logic       id_uses_sr1;
        logic       id_uses_sr2;
        logic [2:0] id_sr1;
        logic [2:0] id_sr2;
        logic       ex_valid;
        logic       ex_is_load;
        logic [2:0] ex_dest;
        logic       mem_valid;
        logic       mem_access;
        logic       mem_indirect;
        logic       mem_br_taken;
        logic       dcache_resp;
    } stim_t;

    // ctl order: load_pc pc_sel if_id id_ex ex_mem mem_wb f_if_id f_id_ex f_ex_mem ind_sel
    typedef struct packed {
        logic [9:0]    ctl;
        logic [CW-1:0] cnt;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic if_req = 1'b0, icache_resp = 1'b0, id_valid = 1'b0, id_uses_sr1 = 1'b0, id_uses_sr2 = 1'b0;
    logic [2:0] id_sr1 = '0, id_sr2 = '0, ex_dest = '0;
    logic ex_valid = 1'b0, ex_is_load = 1'b0;
    logic mem_valid = 1'b0, mem_access = 1'b0, mem_indirect = 1'b0, mem_br_taken = 1'b0, dcache_resp = 1'b0;
    logic load_pc, pc_sel, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex, flush_ex_mem, mem_ind_sel;
    logic [CW-1:0] stall_cycles;

    pipeline_control #(.CNT_WIDTH(CW), .REG_IDX_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .icache_resp(icache_resp),
        .id_valid(id_valid), .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
        .id_sr1(id_sr1), .id_sr2(id_sr2), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_dest(ex_dest), .mem_valid(mem_valid), .mem_access(mem_access),
        .mem_indirect(mem_indirect), .mem_br_taken(mem_br_taken), .dcache_resp(dcache_resp),
        .load_pc(load_pc), .pc_sel(pc_sel), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .mem_ind_sel(mem_ind_sel),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state: waiting on second half of an indirect access, and stall count
    bit   second_access = 1'b0;
    int   stalls        = 0;

    function automatic stim_t quiet();
        stim_t s = '0;
        s.if_req      = 1'b1;
        s.icache_resp = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s, input logic rst);
        exp_t e;
        bit   busy, done, frozen, hazard, redirect;
        @(posedge clk);
        #1;
        rst_n = rst;
        {if_req, icache_resp, id_valid, id_uses_sr1, id_uses_sr2, id_sr1, id_sr2,
         ex_valid, ex_is_load, ex_dest, mem_valid, mem_access, mem_indirect,
         mem_br_taken, dcache_resp} = s;
        e.cyc = cyc;
        cyc++;
        if (!rst) begin
            second_access = 1'b0;
            stalls        = 0;
            e.ctl         = '0;
            e.cnt         = '0;
        end else begin
            busy = s.mem_valid && s.mem_access;
            if (!busy)              done = 1'b1;
            else if (second_access) done = s.dcache_resp;
            else                    done = s.dcache_resp && !s.mem_indirect;
            frozen   = !done || (s.if_req && !s.icache_resp);
            hazard   = s.ex_valid && s.ex_is_load && s.id_valid &&
                       ((s.id_uses_sr1 && s.id_sr1 == s.ex_dest) ||
                        (s.id_uses_sr2 && s.id_sr2 == s.ex_dest));
            redirect = s.mem_valid && s.mem_br_taken;
            if (frozen)        e.ctl = 10'b0000000000;
            else if (redirect) e.ctl = 10'b1111111110;
            else if (hazard)   e.ctl = 10'b0001110100;
            else               e.ctl = 10'b1011110000;
            e.ctl[0] = second_access;
            e.cnt    = CW'((stalls > CNTMAX) ? CNTMAX : stalls);
            if (!e.ctl[9]) stalls++;
            if (second_access) begin
                if (s.dcache_resp) second_access = 1'b0;
            end else if (busy && s.mem_indirect && s.dcache_resp) begin
                second_access = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: combinational outputs settle mid-cycle; compare on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [9:0] got;
            e   = exp_q.pop_front();
            got = {load_pc, pc_sel, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                   flush_if_id, flush_id_ex, flush_ex_mem, mem_ind_sel};
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL ctl cyc=%0d got=%b exp=%b", e.cyc, got, e.ctl);
            end
            checks++;
            if (stall_cycles !== e.cnt) begin
                errors++;
                $display("FAIL stall_cycles cyc=%0d got=%h exp=%h", e.cyc, stall_cycles, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        // reset state
        repeat (2) apply(quiet(), 1'b0);

        // plain ALU stream
        repeat (10) apply(quiet(), 1'b1);

        // load-use: LDR R2 in EX, ADD R?,R2 in ID
        s = quiet();
        s.ex_valid = 1; s.ex_is_load = 1; s.ex_dest = 3'd2;
        s.id_valid = 1; s.id_uses_sr1 = 1; s.id_sr1 = 3'd2;
        apply(s, 1'b1);
        apply(quiet(), 1'b1);
        apply(quiet(), 1'b1);

        // LDI in MEM, responses on cycles 2 and 5
        for (int i = 0; i < 6; i++) begin
            s = quiet();
            s.mem_valid = 1; s.mem_access = 1; s.mem_indirect = 1;
            s.dcache_resp = (i == 2 || i == 5);
            apply(s, 1'b1);
        end
        apply(quiet(), 1'b1);

        // taken branch wins over load-use hazard
        s = quiet();
        s.mem_valid = 1; s.mem_br_taken = 1;
        s.ex_valid = 1; s.ex_is_load = 1; s.ex_dest = 3'd5;
        s.id_valid = 1; s.id_uses_sr2 = 1; s.id_sr2 = 3'd5;
        apply(s, 1'b1);

        // reset while in the second indirect access, then the LDI restarts from scratch
        s = quiet();
        s.mem_valid = 1; s.mem_access = 1; s.mem_indirect = 1; s.dcache_resp = 1;
        apply(s, 1'b1);
        s.dcache_resp = 0;
        apply(s, 1'b1);
        apply(s, 1'b0);
        for (int i = 0; i < 5; i++) begin
            s.dcache_resp = (i == 1 || i == 3);
            apply(s, 1'b1);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s.if_req       = ($urandom_range(0, 9) != 0);
            s.icache_resp  = ($urandom_range(0, 7) != 0);
            s.id_valid     = $urandom_range(0, 1);
            s.id_uses_sr1  = $urandom_range(0, 1);
            s.id_uses_sr2  = $urandom_range(0, 1);
            s.id_sr1       = 3'($urandom_range(0, 3));
            s.id_sr2       = 3'($urandom_range(0, 3));
            s.ex_valid     = $urandom_range(0, 1);
            s.ex_is_load   = $urandom_range(0, 1);
            s.ex_dest      = 3'($urandom_range(0, 3));
            s.mem_valid    = $urandom_range(0, 1);
            s.mem_access   = $urandom_range(0, 1);
            s.mem_indirect = $urandom_range(0, 1);
            s.mem_br_taken = ($urandom_range(0, 4) == 0);
            s.dcache_resp  = $urandom_range(0, 1);
            apply(s, ($urandom_range(0, 199) != 0));
        end

        // counter saturation under a long fetch stall
        apply(quiet(), 1'b0);
        s = quiet();
        s.icache_resp = 0;
        repeat (70000) apply(s, 1'b1);
        repeat (3) apply(quiet(), 1'b1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
